// File: rtl/mcpu_pkg.sv
// Shared definitions for the multicycle CPU controller: state encodings,
// opcode constants and the datapath select codes.
package mcpu_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_R   = 4'd3,
        ST_EXEC_I   = 4'd4,
        ST_MEM_ADDR = 4'd5,
        ST_MEM_RD   = 4'd6,
        ST_MEM_WB   = 4'd7,
        ST_MEM_WR   = 4'd8,
        ST_R_WB     = 4'd9,
        ST_I_WB     = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_LUI   = 3'b100;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/mcpu_opdec.sv
// Opcode decoder: dispatch target for DECODE plus the immediate-ALU
// operation and extension mode used in EXEC_I.
module mcpu_opdec
    import mcpu_pkg::*;
(
    input  logic [5:0] opcode,
    output state_t     dispatch,
    output logic       legal,
    output logic       is_load,
    output logic [2:0] imm_alu_op,
    output logic       imm_ext_op
);

    // Map opcode to the first post-decode state and immediate-ALU controls
    always_comb begin
        dispatch   = ST_FETCH;
        legal      = 1'b1;
        is_load    = 1'b0;
        imm_alu_op = ALU_ADD;
        imm_ext_op = 1'b0;
        case (opcode)
            OP_RTYPE: dispatch = ST_EXEC_R;
            OP_LW: begin
                dispatch = ST_MEM_ADDR;
                is_load  = 1'b1;
            end
            OP_SW:    dispatch = ST_MEM_ADDR;
            OP_BEQ:   dispatch = ST_BRANCH;
            OP_J:     dispatch = ST_JUMP;
            OP_ADDIU: begin
                dispatch   = ST_EXEC_I;
                imm_alu_op = ALU_ADD;
                imm_ext_op = 1'b1;
            end
            OP_ORI: begin
                dispatch   = ST_EXEC_I;
                imm_alu_op = ALU_OR;
            end
            OP_LUI: begin
                dispatch   = ST_EXEC_I;
                imm_alu_op = ALU_LUI;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM. Define MCTRL_MEMWAIT_EN to add the mem_ready
// input, which stalls FETCH, MEM_RD and MEM_WR until memory responds.
module multicycle_ctrl
    import mcpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
`ifdef MCTRL_MEMWAIT_EN
    input  logic       mem_ready,
`endif
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       ext_op,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state_o
);

    state_t     state_q;
    state_t     state_d;
    state_t     dec_state;
    logic       dec_legal;
    logic       dec_load;
    logic [2:0] dec_alu_op;
    logic       dec_ext_op;
    logic       mem_ok;

`ifdef MCTRL_MEMWAIT_EN
    assign mem_ok = mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    mcpu_opdec u_opdec (
        .opcode     (opcode),
        .dispatch   (dec_state),
        .legal      (dec_legal),
        .is_load    (dec_load),
        .imm_alu_op (dec_alu_op),
        .imm_ext_op (dec_ext_op)
    );

    assign state_o = state_q;

    // State register; reset parks the FSM in IDLE, whose outputs are all zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state sequencing; memory states hold until mem_ok
    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_IDLE:     state_d = ST_FETCH;
            ST_FETCH:    state_d = mem_ok ? ST_DECODE : ST_FETCH;
            ST_DECODE:   state_d = dec_legal ? dec_state : ST_FETCH;
            ST_EXEC_R:   state_d = ST_R_WB;
            ST_EXEC_I:   state_d = ST_I_WB;
            ST_MEM_ADDR: state_d = dec_load ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   state_d = mem_ok ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WR:   state_d = mem_ok ? ST_FETCH : ST_MEM_WR;
            ST_MEM_WB,
            ST_R_WB,
            ST_I_WB,
            ST_BRANCH,
            ST_JUMP:     state_d = ST_FETCH;
            default:     state_d = ST_FETCH;
        endcase
    end

    // Per-state control outputs; unlisted states and encodings drive zero
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = PC_SEQ;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_op     = ALU_ADD;
        ext_op     = 1'b0;
        retire     = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = mem_ok;
                pc_write  = mem_ok;
                pc_src    = PC_SEQ;
                alu_src_b = SRCB_ONE;
                alu_op    = ALU_ADD;
            end
            ST_DECODE: begin
                illegal = !dec_legal;
                retire  = !dec_legal;
            end
            ST_EXEC_R: begin
                alu_op    = ALU_FUNCT;
                alu_src_b = SRCB_RT;
            end
            ST_EXEC_I: begin
                alu_src_b = SRCB_IMM;
                alu_op    = dec_alu_op;
                ext_op    = dec_ext_op;
            end
            ST_MEM_ADDR: begin
                alu_op    = ALU_ADD;
                alu_src_b = SRCB_IMM;
                ext_op    = 1'b1;
            end
            ST_MEM_RD: mem_read = 1'b1;
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                reg_dst    = 1'b0;
                retire     = 1'b1;
            end
            ST_MEM_WR: begin
                mem_write = 1'b1;
                retire    = mem_ok;
            end
            ST_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                mem_to_reg = 1'b0;
                retire     = 1'b1;
            end
            ST_I_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b0;
                retire    = 1'b1;
            end
            ST_BRANCH: begin
                alu_op    = ALU_SUB;
                alu_src_b = SRCB_RT;
                pc_src    = PC_BRANCH;
                pc_write  = zero;
                retire    = 1'b1;
            end
            ST_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PC_JUMP;
                retire   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: instruction-level timeline model,
// random opcode/zero stimulus, async reset mid-instruction.
module tb_multicycle_ctrl;
    import mcpu_pkg::*;

    typedef enum int {C_R, C_I, C_LW, C_SW, C_BEQ, C_J, C_ILL} cls_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic       zero = 1'b0;
`ifdef MCTRL_MEMWAIT_EN
    logic       mem_ready = 1'b1;
`endif
    logic       pc_write, ir_write, mem_read, mem_write;
    logic       reg_write, reg_dst, mem_to_reg, ext_op, retire, illegal;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] alu_op;
    logic [3:0] state_o;
    logic [20:0] obs;

    int errors = 0;
    int checks = 0;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
`ifdef MCTRL_MEMWAIT_EN
        .mem_ready  (mem_ready),
`endif
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .ext_op     (ext_op),
        .retire     (retire),
        .illegal    (illegal),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    assign obs = {state_o, pc_write, pc_src, ir_write, mem_read, mem_write,
                  reg_write, reg_dst, mem_to_reg, alu_src_b, alu_op, ext_op,
                  retire, illegal};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, want);
        end
    endtask

    function automatic cls_t cls_of(input logic [5:0] op);
        case (op)
            OP_RTYPE:                 return C_R;
            OP_LW:                    return C_LW;
            OP_SW:                    return C_SW;
            OP_BEQ:                   return C_BEQ;
            OP_J:                     return C_J;
            OP_ADDIU, OP_ORI, OP_LUI: return C_I;
            default:                  return C_ILL;
        endcase
    endfunction

    // Cycles from FETCH to retire inclusive, excluding memory stalls
    function automatic int inst_len(input cls_t c);
        case (c)
            C_LW:         return 5;
            C_R, C_I, C_SW: return 4;
            C_BEQ, C_J:   return 3;
            default:      return 2;
        endcase
    endfunction

    // Steps that wait on memory: FETCH and the lw/sw data access
    function automatic bit is_wait_step(input cls_t c, input int k);
        return (k == 0) || (k == 3 && (c == C_LW || c == C_SW));
    endfunction

    // Expected output vector for step k of an instruction with opcode op
    function automatic logic [20:0] model(input logic [5:0] op, input int k,
                                          input logic z, input logic rdy);
        cls_t       c = cls_of(op);
        state_t     st = ST_IDLE;
        logic       pw = 0, irw = 0, mr = 0, mw = 0, rw = 0, rd = 0, m2r = 0;
        logic       eo = 0, ret = 0, ill = 0;
        logic [1:0] ps = 2'b00, sb = 2'b00;
        logic [2:0] ao = 3'b000;
        if (k == 0) begin
            st = ST_FETCH; mr = 1; sb = 2'b01; pw = rdy; irw = rdy;
        end else if (k == 1) begin
            st = ST_DECODE;
            if (c == C_ILL) begin ill = 1; ret = 1; end
        end else begin
            case (c)
                C_R: if (k == 2) begin st = ST_EXEC_R; ao = 3'b010; end
                     else begin st = ST_R_WB; rw = 1; rd = 1; ret = 1; end
                C_I: if (k == 2) begin
                         st = ST_EXEC_I; sb = 2'b10;
                         if (op == OP_ADDIU) begin ao = 3'b000; eo = 1; end
                         else if (op == OP_ORI) ao = 3'b011;
                         else ao = 3'b100;
                     end else begin st = ST_I_WB; rw = 1; ret = 1; end
                C_LW: if (k == 2) begin st = ST_MEM_ADDR; sb = 2'b10; eo = 1; end
                      else if (k == 3) begin st = ST_MEM_RD; mr = 1; end
                      else begin st = ST_MEM_WB; rw = 1; m2r = 1; ret = 1; end
                C_SW: if (k == 2) begin st = ST_MEM_ADDR; sb = 2'b10; eo = 1; end
                      else begin st = ST_MEM_WR; mw = 1; ret = rdy; end
                C_BEQ: begin st = ST_BRANCH; ao = 3'b001; ps = 2'b01; pw = z; ret = 1; end
                C_J:   begin st = ST_JUMP; ps = 2'b10; pw = 1; ret = 1; end
                default: ;
            endcase
        end
        return {st, pw, ps, irw, mr, mw, rw, rd, m2r, sb, ao, eo, ret, ill};
    endfunction

    // Pulse reset just after the sample point; outputs must clear at once,
    // stay clear across the next edge, and IDLE must show at release.
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_eq({tag, "_async"}, {11'd0, obs}, 32'd0);
        @(negedge clk);
        check_eq({tag, "_held"}, {11'd0, obs}, 32'd0);
        rst_n = 1'b1;
        #1 check_eq({tag, "_idle"}, {28'd0, state_o}, {28'd0, ST_IDLE});
    endtask

    // Run one instruction starting with FETCH at the next rising edge.
    // zmode<0 randomizes zero; fetch_stall forces mem_ready low in FETCH;
    // abort_k>=0 applies reset after checking that step.
    task automatic run_inst(input logic [5:0] op, input int zmode,
                            input int fetch_stall, input int abort_k);
        cls_t  c = cls_of(op);
        int    len = inst_len(c);
        int    k = 0;
        int    hold = 0;
        logic  rdy;
        string tag;
        while (k < len) begin
            @(posedge clk);
            #1;
            if (k == 0) opcode = op;
            zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : zmode[0];
            rdy = 1'b1;
`ifdef MCTRL_MEMWAIT_EN
            if (k == 0 && fetch_stall > 0) rdy = (hold < fetch_stall) ? 1'b0 : 1'b1;
            else rdy = ($urandom_range(0, 3) != 0);
            mem_ready = rdy;
`endif
            @(negedge clk);
            tag = $sformatf("op%02h_k%0d", op, k);
            check_eq(tag, {11'd0, obs}, {11'd0, model(op, k, zero, rdy)});
            if (k == abort_k) begin
                async_reset(tag);
                return;
            end
            if (is_wait_step(c, k) && !rdy) hold++;
            else begin
                k++;
                hold = 0;
            end
        end
        if (fetch_stall < 0) $display("unused");
    endtask

    logic [5:0] op_table [8] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
                                 OP_J, OP_ADDIU, OP_ORI, OP_LUI};

    initial begin
        #3 check_eq("reset_outputs", {11'd0, obs}, 32'd0);
        @(negedge clk);
        check_eq("reset_held", {11'd0, obs}, 32'd0);
        rst_n = 1'b1;
        #1 check_eq("release_idle", {28'd0, state_o}, {28'd0, ST_IDLE});

        run_inst(OP_LW, -1, 0, -1);
        run_inst(OP_BEQ, 1, 0, -1);
        run_inst(OP_BEQ, 0, 0, -1);
        run_inst(OP_J, -1, 0, -1);
        run_inst(6'b111111, -1, 0, -1);
        run_inst(OP_SW, -1, 0, -1);
        run_inst(OP_RTYPE, -1, 0, -1);
        run_inst(OP_ADDIU, -1, 0, -1);
        run_inst(OP_ORI, -1, 0, -1);
        run_inst(OP_LUI, -1, 0, -1);
        run_inst(OP_LW, -1, 0, 4);
        run_inst(OP_RTYPE, -1, 0, -1);
`ifdef MCTRL_MEMWAIT_EN
        run_inst(OP_RTYPE, -1, 3, -1);
`endif

        for (int n = 0; n < 200; n++) begin
            logic [5:0] op;
            int         abort;
            if ($urandom_range(0, 9) >= 8) op = 6'($urandom);
            else op = op_table[$urandom_range(0, 7)];
            abort = -1;
            if ($urandom_range(0, 15) == 0)
                abort = $urandom_range(0, inst_len(cls_of(op)) - 1);
            run_inst(op, -1, 0, abort);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
